mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  instruction opcode, Instr[6:0].
REQ-005 funct3  input  3  Instr[14:12].
REQ-006 funct7b5  input  1  Instr[30].
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  PC enable, address mux, data-memory write, instruction-register enable, register-file write.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  result mux, ALU A mux, ALU B mux, and immediate-extender select (00 I, 01 S, 10 B, 11 J).
REQ-010 ALUControl  output  3  ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-011 state  output  4  current FSM state, for debug.

Function
REQ-012 The block SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, advancing one state per clk.
REQ-013 Transitions SHALL be as follows.
- FETCH->DECODE.
- From DECODE:
  - op 0000011 (lw) or 0100011 (sw) -> MEMADR.
  - op 0110011 (R-type) -> EXECUTER.
  - op 0010011 (I-type ALU) -> EXECUTEI.
  - op 1101111 (jal) -> JAL.
  - op 1100011 (beq) -> BEQ.
  - any other op -> FETCH (NOP, no side effects).
- From MEMADR: lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER->ALUWB; EXECUTEI->ALUWB; JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- Encodings 11-15 -> FETCH.
REQ-014 Per-state outputs SHALL be as listed; every unlisted output is 0 in that state.
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
REQ-015 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), evaluated combinationally in the same cycle.
REQ-016 ImmSrc SHALL be decoded combinationally from op in every state.
- sw -> 01; beq -> 10; jal -> 11.
- lw, I-type and any other op -> 00.
REQ-017 ALUControl SHALL be decoded from the internal ALUOp as follows.
- ALUOp 00 -> 000; ALUOp 01 -> 001; ALUOp 11 -> 000.
- ALUOp 10, by funct3:
  - 000: 001 if (op[5] AND funct7b5), else 000.
  - 010 -> 101; 110 -> 011; 111 -> 010.
  - other -> 000.
REQ-018 funct7b5 SHALL be ignored for I-type instructions (op[5]=0), so addi never subtracts.
REQ-019 Each instruction SHALL take a fixed number of cycles.
- lw 5; sw 4; R-type 4; I-type 4; jal 4; beq 3; unknown op 2.

Reset
REQ-020 Asserting reset SHALL force the state to FETCH immediately, independent of clk, including mid-instruction.
REQ-021 While reset is high, PCWrite, IRWrite, MemWrite and RegWrite SHALL be 0; all other outputs SHALL show their FETCH values.
REQ-022 On the first rising clk after reset deasserts, the FSM SHALL be in FETCH with enables active, then proceed normally.

Verification
REQ-023 Reset, then lw (op=0000011) -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; ResultSrc=01 in state 4; ImmSrc=00.
REQ-024 sw (op=0100011) -> states 0,1,2,5,0; MemWrite=1 and AdrSrc=1 only in state 5; ImmSrc=01.
REQ-025 R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER; the same inputs with op=0010011 -> ALUControl=000; slt (funct3=010) -> 101.
REQ-026 beq (op=1100011) in BEQ state: with Zero=1, PCWrite=1; with Zero=0, PCWrite=0. ImmSrc=10 and ALUControl=001 in both cases.
REQ-027 jal (op=1101111) -> states 0,1,9,7,0; PCWrite=1 in state 9; ImmSrc=11.
REQ-028 Reset asserted mid-MEMWRITE, between clock edges -> state=0 and MemWrite=0 within the same cycle; an unknown op (0000000) -> states 0,1,0 with no write enable asserted in state 1.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle RISC-V main controller: Moore FSM sequencing fetch/decode/execute,
// plus combinational immediate-select and ALU-control decoders.
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t     state_q, state_d;
  logic       pc_update, branch;
  logic       adr_src, mem_write, ir_write, reg_write;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    adr_src   = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are forced low while reset is held so no stray writes occur.
  assign PCWrite  = ~reset & (pc_update | (branch & Zero));
  assign IRWrite  = ~reset & ir_write;
  assign MemWrite = ~reset & mem_write;
  assign RegWrite = ~reset & reg_write;
  assign AdrSrc   = adr_src;
  assign state    = state_q;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // op[5] separates R-type from I-type so addi with Instr[30] set still adds.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed instruction scenarios plus randomized
// instruction streams checked against a table-driven reference model.
module tb_mc_control;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  logic [15:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

  typedef int iq_t[$];

  // State visit list for one instruction, from its cycle count and path.
  function automatic iq_t instr_seq(input logic [6:0] o);
    iq_t s;
    if (o == OP_LW)       s = '{0, 1, 2, 3, 4};
    else if (o == OP_SW)  s = '{0, 1, 2, 5};
    else if (o == OP_R)   s = '{0, 1, 6, 7};
    else if (o == OP_I)   s = '{0, 1, 8, 7};
    else if (o == OP_JAL) s = '{0, 1, 9, 7};
    else if (o == OP_BEQ) s = '{0, 1, 10};
    else                  s = '{0, 1};
    return s;
  endfunction

  // Expected output vector for a state, straight from the per-state table.
  function automatic logic [15:0] model_out(input int st, input logic [6:0] o,
      input logic [2:0] f3, input logic f7, input logic z);
    logic pcu, br, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, imm, aop;
    logic [2:0] ac;
    {pcu, br, adr, mw, irw, rw} = '0;
    rs = 0; sa = 0; sb = 0; aop = 0;
    case (st)
      0:  begin irw = 1; sb = 2; rs = 2; pcu = 1; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; aop = 2; end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; aop = 2; end
      9:  begin sa = 1; sb = 2; pcu = 1; end
      10: begin sa = 2; aop = 1; br = 1; end
      default: ;
    endcase
    if (o == OP_SW) imm = 1;
    else if (o == OP_BEQ) imm = 2;
    else if (o == OP_JAL) imm = 3;
    else imm = 0;
    ac = 3'b000;
    if (aop == 1) ac = 3'b001;
    else if (aop == 2) begin
      if (f3 == 0)      ac = (o == OP_R && f7) ? 3'b001 : 3'b000;
      else if (f3 == 2) ac = 3'b101;
      else if (f3 == 6) ac = 3'b011;
      else if (f3 == 7) ac = 3'b010;
    end
    return {pcu | (br & z), adr, mw, irw, rw, rs, sa, sb, imm, ac};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    op = OP_LW; funct3 = 3'b000; funct7b5 = 0; Zero = 1;
    reset = 1'b1;
    #1;
    n_tests++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_tests++;
    if (obs !== {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000}) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, {5'b00000, 8'b10001000, 3'b000});
    end
    @(posedge clk); #2;
    n_tests++;
    if (state !== 4'd0 || PCWrite !== 1'b0 || IRWrite !== 1'b0) begin
      n_fail++; $display("FAIL reset_held: got state=%0d PCWrite=%b IRWrite=%b expected 0,0,0", state, PCWrite, IRWrite);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (state !== 4'd0 || PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: got state=%0d PCWrite=%b IRWrite=%b expected 0,1,1", state, PCWrite, IRWrite);
    end
  endtask

  task automatic test_lw();
    int exp_s[5] = '{0, 1, 2, 3, 4};
    op = OP_LW; funct3 = 3'b010; funct7b5 = 1; Zero = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (state !== 4'(exp_s[k])) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d expected %0d", k, state, exp_s[k]); end
      n_tests++;
      if (RegWrite !== (exp_s[k] == 4)) begin n_fail++; $display("FAIL lw_regwrite[%0d]: got %b expected %b", k, RegWrite, exp_s[k] == 4); end
      n_tests++;
      if (ImmSrc !== 2'b00) begin n_fail++; $display("FAIL lw_immsrc[%0d]: got %b expected 00", k, ImmSrc); end
      if (exp_s[k] == 4) begin
        n_tests++;
        if (ResultSrc !== 2'b01) begin n_fail++; $display("FAIL lw_resultsrc: got %b expected 01", ResultSrc); end
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL lw_return: got %0d expected 0", state); end
  endtask

  task automatic test_sw();
    int exp_s[4] = '{0, 1, 2, 5};
    op = OP_SW; funct3 = 3'b010; funct7b5 = 0; Zero = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++;
      if (state !== 4'(exp_s[k])) begin n_fail++; $display("FAIL sw_state[%0d]: got %0d expected %0d", k, state, exp_s[k]); end
      n_tests++;
      if (MemWrite !== (exp_s[k] == 5) || AdrSrc !== (exp_s[k] == 5)) begin
        n_fail++; $display("FAIL sw_memwrite[%0d]: got %b%b expected %0d%0d", k, MemWrite, AdrSrc, exp_s[k] == 5, exp_s[k] == 5);
      end
      n_tests++;
      if (ImmSrc !== 2'b01) begin n_fail++; $display("FAIL sw_immsrc[%0d]: got %b expected 01", k, ImmSrc); end
      @(posedge clk); #1;
    end
    n_tests++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL sw_return: got %0d expected 0", state); end
  endtask

  task automatic test_alu_decode();
    logic [6:0] ops[3]   = '{OP_R, OP_I, OP_R};
    logic [2:0] f3s[3]   = '{3'b000, 3'b000, 3'b010};
    logic [3:0] exst[3]  = '{4'd6, 4'd8, 4'd6};
    logic [2:0] exac[3]  = '{3'b001, 3'b000, 3'b101};
    for (int k = 0; k < 3; k++) begin
      op = ops[k]; funct3 = f3s[k]; funct7b5 = 1; Zero = 0;
      @(posedge clk); @(posedge clk); #2;
      n_tests++;
      if (state !== exst[k] || ALUControl !== exac[k]) begin
        n_fail++; $display("FAIL alu_decode[%0d]: got state=%0d alu=%b expected %0d,%b", k, state, ALUControl, exst[k], exac[k]);
      end
      @(posedge clk); @(posedge clk); #2;
      n_tests++;
      if (state !== 4'd0) begin n_fail++; $display("FAIL alu_return[%0d]: got %0d expected 0", k, state); end
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      op = OP_BEQ; funct3 = 3'b000; funct7b5 = 0; Zero = 0;
      @(posedge clk); @(posedge clk); #2;
      Zero = 1'(z);
      #1;
      n_tests++;
      if (state !== 4'd10 || PCWrite !== 1'(z)) begin
        n_fail++; $display("FAIL beq_pcwrite_z%0d: got state=%0d PCWrite=%b expected 10,%0d", z, state, PCWrite, z);
      end
      n_tests++;
      if (ImmSrc !== 2'b10 || ALUControl !== 3'b001) begin
        n_fail++; $display("FAIL beq_decode_z%0d: got imm=%b alu=%b expected 10,001", z, ImmSrc, ALUControl);
      end
      @(posedge clk); #2;
      n_tests++;
      if (state !== 4'd0) begin n_fail++; $display("FAIL beq_return: got %0d expected 0", state); end
    end
  endtask

  task automatic test_jal();
    int exp_s[4] = '{0, 1, 9, 7};
    op = OP_JAL; funct3 = 3'b000; funct7b5 = 0; Zero = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++;
      if (state !== 4'(exp_s[k]) || ImmSrc !== 2'b11) begin
        n_fail++; $display("FAIL jal_state[%0d]: got state=%0d imm=%b expected %0d,11", k, state, ImmSrc, exp_s[k]);
      end
      if (exp_s[k] == 9) begin
        n_tests++;
        if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL jal_pcwrite: got %b expected 1", PCWrite); end
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL jal_return: got %0d expected 0", state); end
  endtask

  task automatic test_nop();
    op = 7'b0000000; funct3 = 3'b111; funct7b5 = 1; Zero = 1;
    @(posedge clk); #2;
    n_tests++;
    if (state !== 4'd1 || {PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
      n_fail++; $display("FAIL nop_decode: got state=%0d en=%b expected 1,0000", state, {PCWrite, MemWrite, RegWrite, IRWrite});
    end
    @(posedge clk); #2;
    n_tests++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL nop_return: got %0d expected 0", state); end
  endtask

  task automatic test_mid_reset();
    op = OP_SW; funct3 = 3'b010; funct7b5 = 0; Zero = 0;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    n_tests++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: got state=%0d MemWrite=%b expected 5,1", state, MemWrite);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (state !== 4'd0 || MemWrite !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async: got state=%0d MemWrite=%b expected 0,0", state, MemWrite);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL midreset_release: got %0d expected 0", state); end
  endtask

  task automatic test_random();
    logic [6:0] pool[6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
    iq_t seq;
    logic [15:0] exp_o;
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : pool[$urandom_range(0, 5)];
      funct3 = 3'($urandom); funct7b5 = 1'($urandom);
      seq = instr_seq(op);
      foreach (seq[k]) begin
        Zero = 1'($urandom);
        #1;
        exp_o = model_out(seq[k], op, funct3, funct7b5, Zero);
        n_tests++;
        if (state !== 4'(seq[k]) || obs !== exp_o) begin
          n_fail++;
          $display("FAIL rand[%0d.%0d] op=%b: got state=%0d out=%h expected %0d,%h", n, k, op, state, obs, seq[k], exp_o);
        end
        @(posedge clk); #1;
      end
    end
    #1;
    n_tests++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL rand_return: got %0d expected 0", state); end
  endtask

  initial begin
    reset = 1'b0; op = '0; funct3 = '0; funct7b5 = 0; Zero = 0;
    test_reset();
    test_lw();
    test_sw();
    test_alu_decode();
    test_beq();
    test_jal();
    test_nop();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
